mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 492 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (I-cache / D-cache) round-robin arbiter in front of a single-outstanding main-memory port.
// Latency: grant edge to resp edge = 2 + memory latency cycles; mem_req holds with stable fields while mem_ready is low.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int BLOCK_BITS = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r0_req,
  input  logic                  r0_rw,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [BLOCK_BITS-1:0] r0_wdata,
  input  logic                  r1_req,
  input  logic                  r1_rw,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [BLOCK_BITS-1:0] r1_wdata,
  output logic                  r0_resp,
  output logic                  r1_resp,
  output logic [BLOCK_BITS-1:0] rdata,
  output logic                  mem_req,
  output logic                  mem_rw,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [BLOCK_BITS-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic                  mem_resp,
  input  logic [BLOCK_BITS-1:0] mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  typedef struct packed {
    logic                  rw;
    logic [ADDR_WIDTH-1:0] addr;
    logic [BLOCK_BITS-1:0] wdata;
  } req_t;

  state_t state;
  logic   owner;
  logic   last_grant;
  logic   grant;
  req_t   sel_req;

  // On a tie the requester not granted last wins; a lone request wins outright.
  always_comb begin
    grant = r1_req;
    if (r0_req && r1_req) begin
      grant = ~last_grant;
    end
    if (grant) begin
      sel_req.rw    = r1_rw;
      sel_req.addr  = r1_addr;
      sel_req.wdata = r1_wdata;
    end else begin
      sel_req.rw    = r0_rw;
      sel_req.addr  = r0_addr;
      sel_req.wdata = r0_wdata;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      mem_req    <= 1'b0;
      mem_rw     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      r0_resp    <= 1'b0;
      r1_resp    <= 1'b0;
      rdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (r0_req || r1_req) begin
            owner      <= grant;
            last_grant <= grant;
            mem_req    <= 1'b1;
            mem_rw     <= sel_req.rw;
            mem_addr   <= sel_req.addr;
            mem_wdata  <= sel_req.wdata;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          // Write completions also return mem_rdata so both directions look alike to the caches.
          if (mem_resp) begin
            rdata   <= mem_rdata;
            r0_resp <= ~owner;
            r1_resp <= owner;
            state   <= DONE;
          end
        end
        DONE: begin
          r0_resp <= 1'b0;
          r1_resp <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two requester agents, a randomised memory slave and a per-requester scoreboard.
module tb_mem_arbiter;

  typedef struct {
    logic         rw;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic [255:0] exp;
  } txn_t;

  logic         clk;
  logic         rst;
  logic [1:0]   req_v;
  logic [1:0]   rw_v;
  logic [31:0]  addr_v [2];
  logic [255:0] wdata_v [2];
  logic         r0_resp, r1_resp;
  logic [1:0]   resp_v;
  logic [255:0] rdata;
  logic         mem_req, mem_rw;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic         mem_ready, mem_resp;
  logic [255:0] mem_rdata;
  logic         busy;

  int checks = 0;
  int failures = 0;

  txn_t         aq [2][$];
  txn_t         exp_q [2][$];
  logic [1:0]   active;
  int           order_log[$];
  logic [255:0] rdata_log[$];
  logic [255:0] ref_mem [logic [31:0]];
  logic [255:0] slv_mem [logic [31:0]];

  int stall_left = 0, stall_max = 0, lat_min = 0, lat_max = 0, spur_en = 0;
  logic         cap_rw;
  logic [31:0]  cap_addr;
  logic [255:0] cap_wdata;

  assign resp_v = {r1_resp, r0_resp};

  mem_arbiter #(.ADDR_WIDTH(32), .BLOCK_BITS(256)) dut (
    .clk(clk), .rst(rst),
    .r0_req(req_v[0]), .r0_rw(rw_v[0]), .r0_addr(addr_v[0]), .r0_wdata(wdata_v[0]),
    .r1_req(req_v[1]), .r1_rw(rw_v[1]), .r1_addr(addr_v[1]), .r1_wdata(wdata_v[1]),
    .r0_resp(r0_resp), .r1_resp(r1_resp), .rdata(rdata),
    .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Power-on memory contents: every 32-bit word holds its own byte address.
  function automatic logic [255:0] pattern(input logic [31:0] a);
    logic [255:0] b;
    for (int i = 0; i < 8; i++) b[32*i +: 32] = a + 32'(4 * i);
    return b;
  endfunction

  function automatic logic [255:0] ref_read(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return pattern(a);
  endfunction

  function automatic logic [255:0] rand_blk();
    logic [255:0] b;
    for (int i = 0; i < 8; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  task automatic issue(input int id, input logic rw, input logic [31:0] addr, input logic [255:0] wd);
    txn_t t;
    t.rw = rw; t.addr = addr; t.wdata = wd;
    if (rw) begin
      t.exp = wd;
      ref_mem[addr] = wd;
    end else begin
      t.exp = ref_read(addr);
    end
    aq[id].push_back(t);
    exp_q[id].push_back(t);
  endtask

  task automatic drain(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (aq[0].size() == 0 && aq[1].size() == 0 && active == 2'b00 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Requester agents: hold req with stable fields until resp, then present the next queued item.
  initial begin
    txn_t tmp;
    req_v = '0; rw_v = '0; active = '0;
    addr_v[0] = '0; addr_v[1] = '0; wdata_v[0] = '0; wdata_v[1] = '0;
    forever begin
      @(negedge clk);
      for (int id = 0; id < 2; id++) begin
        if (rst) begin
          req_v[id]  = 1'b0;
          active[id] = 1'b0;
        end else begin
          if (active[id] && resp_v[id]) begin
            tmp = aq[id].pop_front();
            active[id] = 1'b0;
            req_v[id]  = 1'b0;
          end
          if (!active[id] && aq[id].size() > 0) begin
            rw_v[id]    = aq[id][0].rw;
            addr_v[id]  = aq[id][0].addr;
            wdata_v[id] = aq[id][0].wdata;
            req_v[id]   = 1'b1;
            active[id]  = 1'b1;
          end
        end
      end
    end
  end

  // Memory slave: optional stall, random service latency, optional stray mem_resp pulses outside WAIT.
  initial begin
    int mph;
    int lat_left;
    logic [255:0] resp_blk;
    mph = 0; lat_left = 0; resp_blk = '0;
    mem_ready = 1'b0; mem_resp = 1'b0; mem_rdata = '0;
    cap_rw = 1'b0; cap_addr = '0; cap_wdata = '0;
    forever begin
      @(negedge clk);
      mem_resp = 1'b0;
      if (rst) begin
        mph = 0;
        mem_ready = 1'b0;
      end else begin
        case (mph)
          0: begin
            if (mem_req) begin
              if (stall_left > 0) begin
                stall_left--;
                mem_ready = 1'b0;
                if (spur_en != 0) begin
                  mem_resp = 1'b1;
                  mem_rdata = rand_blk();
                end
              end else begin
                mem_ready = 1'b1;
                mph = 1;
              end
            end else if (spur_en != 0 && $urandom_range(0, 1) == 1) begin
              mem_resp = 1'b1;
              mem_rdata = rand_blk();
            end
          end
          1: begin
            mem_ready = 1'b0;
            cap_rw = mem_rw; cap_addr = mem_addr; cap_wdata = mem_wdata;
            if (mem_rw) begin
              slv_mem[mem_addr] = mem_wdata;
              resp_blk = mem_wdata;
            end else begin
              resp_blk = slv_mem.exists(mem_addr) ? slv_mem[mem_addr] : pattern(mem_addr);
            end
            lat_left = $urandom_range(lat_min, lat_max);
            mph = 2;
          end
          default: begin
            if (lat_left > 0) begin
              lat_left--;
            end else begin
              mem_resp = 1'b1;
              mem_rdata = resp_blk;
              stall_left = $urandom_range(0, stall_max);
              mph = 0;
            end
          end
        endcase
      end
    end
  end

  // Scoreboard: every resp must belong to a pending request of that requester, in its program order.
  always @(negedge clk) begin
    txn_t sb;
    if (!rst) begin
      if (r0_resp || r1_resp) begin
        checks++;
        if (r0_resp && r1_resp) begin
          failures++;
          $display("FAIL resp_exclusive: r0_resp=%b r1_resp=%b, at most one required", r0_resp, r1_resp);
        end
      end
      for (int id = 0; id < 2; id++) begin
        if (resp_v[id]) begin
          order_log.push_back(id);
          rdata_log.push_back(rdata);
          checks++;
          if (exp_q[id].size() == 0) begin
            failures++;
            $display("FAIL unexpected_resp: r%0d_resp with no pending request", id);
          end else begin
            sb = exp_q[id].pop_front();
            if (rdata !== sb.exp) begin
              failures++;
              $display("FAIL rdata_r%0d: got %h expected %h", id, rdata, sb.exp);
            end
            checks++;
            if (cap_addr !== sb.addr || cap_rw !== sb.rw) begin
              failures++;
              $display("FAIL mem_fields_r%0d: got rw=%b addr=%h expected rw=%b addr=%h", id, cap_rw, cap_addr, sb.rw, sb.addr);
            end
            if (sb.rw) begin
              checks++;
              if (cap_wdata !== sb.wdata) begin
                failures++;
                $display("FAIL mem_wdata_r%0d: got %h expected %h", id, cap_wdata, sb.wdata);
              end
            end
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_req, mem_rw, r0_resp, r1_resp, busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got req/rw/r0/r1/busy=%b expected 00000", {mem_req, mem_rw, r0_resp, r1_resp, busy});
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 256'h0 || rdata !== 256'h0) begin
      failures++;
      $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h expected zeros", mem_addr, mem_wdata, rdata);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got busy=%b mem_req=%b expected 0 0", busy, mem_req);
    end
  endtask

  task automatic test_single_read();
    bit ok;
    int n;
    int seen;
    stall_left = 0; stall_max = 0; lat_min = 0; lat_max = 0; spur_en = 0;
    issue(0, 1'b0, 32'h40, 256'h0);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_req) begin seen = 1; break; end
    end
    checks++;
    if (seen == 0 || mem_addr !== 32'h40 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_issue: got mem_req=%b addr=%h busy=%b expected 1 00000040 1", mem_req, mem_addr, busy);
    end
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n++;
      if (r0_resp) break;
    end
    // The slave answers one cycle after accepting, so grant-to-resp is 2 + 1 edges.
    checks++;
    if (n != 3 || r0_resp !== 1'b1) begin
      failures++;
      $display("FAIL single_latency: got %0d cycles resp=%b expected 3 cycles", n, r0_resp);
    end
    checks++;
    if (rdata[31:0] !== 32'h40 || rdata[255:224] !== 32'h5C) begin
      failures++;
      $display("FAIL single_rdata: got w0=%h w7=%h expected 00000040 0000005c", rdata[31:0], rdata[255:224]);
    end
    @(negedge clk);
    checks++;
    if (r0_resp !== 1'b0 || r1_resp !== 1'b0) begin
      failures++;
      $display("FAIL resp_pulse_width: got r0=%b r1=%b one cycle later expected 0 0", r0_resp, r1_resp);
    end
    drain(100, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_drain: timeout expected completion"); end
  endtask

  task automatic test_write_read();
    bit ok;
    logic [255:0] wblk;
    int base;
    for (int i = 0; i < 8; i++) wblk[32*i +: 32] = 32'hA0 + 32'(i);
    base = rdata_log.size();
    issue(1, 1'b1, 32'h100, wblk);
    issue(1, 1'b0, 32'h100, 256'h0);
    drain(200, ok);
    checks++;
    if (!ok || rdata_log.size() != base + 2) begin
      failures++;
      $display("FAIL wr_rd_count: got %0d completions expected 2 (drained=%0d)", rdata_log.size() - base, ok);
    end else begin
      checks++;
      if (rdata_log[base + 1][31:0] !== 32'hA0 || rdata_log[base + 1][255:224] !== 32'hA7) begin
        failures++;
        $display("FAIL wr_rd_data: got w0=%h w7=%h expected a0 a7", rdata_log[base + 1][31:0], rdata_log[base + 1][255:224]);
      end
    end
  endtask

  task automatic test_tie();
    bit ok;
    int base;
    do_reset();
    base = order_log.size();
    issue(0, 1'b0, 32'h1000, 256'h0);
    issue(1, 1'b0, 32'h2000, 256'h0);
    drain(200, ok);
    checks++;
    if (!ok || order_log.size() != base + 2) begin
      failures++;
      $display("FAIL tie_count: got %0d completions expected 2", order_log.size() - base);
    end else begin
      checks++;
      if (order_log[base] != 0 || order_log[base + 1] != 1) begin
        failures++;
        $display("FAIL tie_order: got r%0d,r%0d expected r0,r1", order_log[base], order_log[base + 1]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int seen;
    int bad;
    logic [31:0] a0;
    int base;
    base = order_log.size();
    stall_left = 5; spur_en = 1;
    issue(1, 1'b0, 32'h2040, 256'h0);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_req) begin seen = 1; break; end
    end
    a0 = mem_addr;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (mem_req !== 1'b1 || mem_addr !== 32'h2040 || r1_resp !== 1'b0 || r0_resp !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (seen == 0 || bad != 0) begin
      failures++;
      $display("FAIL backpressure_hold: %0d bad stall cycles, first addr=%h expected 0 and 00002040", bad, a0);
    end
    spur_en = 0;
    drain(200, ok);
    checks++;
    if (!ok || order_log.size() != base + 1) begin
      failures++;
      $display("FAIL backpressure_done: got %0d completions expected 1", order_log.size() - base);
    end
  endtask

  task automatic test_contention();
    bit ok;
    int base;
    int bad;
    do_reset();
    base = order_log.size();
    for (int k = 0; k < 3; k++) begin
      issue(0, 1'b0, 32'h1000 + 32'(32 * k), 256'h0);
      issue(1, 1'b0, 32'h2000 + 32'(32 * k), 256'h0);
    end
    drain(500, ok);
    checks++;
    if (!ok || order_log.size() != base + 6) begin
      failures++;
      $display("FAIL contention_count: got %0d completions expected 6", order_log.size() - base);
    end else begin
      bad = 0;
      for (int k = 0; k < 6; k++) if (order_log[base + k] != (k % 2)) bad++;
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL contention_order: got %0d out-of-turn grants expected alternating r0,r1", bad);
      end
    end
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    int base;
    int seen;
    lat_min = 20; lat_max = 20;
    base = order_log.size();
    issue(0, 1'b0, 32'h10E0, 256'h0);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy && !mem_req) begin seen = 1; break; end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (seen == 0 || busy !== 1'b0 || mem_req !== 1'b0 || r0_resp !== 1'b0 || mem_addr !== 32'h0 || rdata !== 256'h0) begin
      failures++;
      $display("FAIL reset_in_wait: reached=%0d busy=%b mem_req=%b r0_resp=%b addr=%h expected 1 0 0 0 0", seen, busy, mem_req, r0_resp, mem_addr);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    lat_min = 0; lat_max = 2;
    @(negedge clk);
    checks++;
    if (order_log.size() != base) begin
      failures++;
      $display("FAIL reset_no_resp: got %0d completions expected 0", order_log.size() - base);
    end
    drain(300, ok);
    checks++;
    if (!ok || order_log.size() != base + 1) begin
      failures++;
      $display("FAIL reset_rerequest: got %0d completions expected 1", order_log.size() - base);
    end
  endtask

  task automatic test_random_traffic();
    bit ok;
    int base;
    int id;
    stall_max = 3; lat_min = 0; lat_max = 3; spur_en = 1;
    base = order_log.size();
    for (int burst = 0; burst < 8; burst++) begin
      for (int k = 0; k < 5; k++) begin
        id = $urandom_range(0, 1);
        issue(id, 1'($urandom_range(0, 1)), (id == 1 ? 32'h2000 : 32'h1000) + 32'(32 * $urandom_range(0, 7)), rand_blk());
      end
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    drain(20000, ok);
    checks++;
    if (!ok || order_log.size() != base + 40) begin
      failures++;
      $display("FAIL random_count: got %0d completions expected 40", order_log.size() - base);
    end
    stall_max = 0; spur_en = 0;
  endtask

  task automatic test_final();
    checks++;
    if (exp_q[0].size() != 0 || exp_q[1].size() != 0) begin
      failures++;
      $display("FAIL pending_left: got %0d/%0d unserved expected 0/0", exp_q[0].size(), exp_q[1].size());
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single_read();
    test_write_read();
    test_tie();
    test_backpressure();
    test_contention();
    test_reset_in_wait();
    test_random_traffic();
    test_final();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
